// File: rtl/pc_gen_pkg.sv
// Shared types and the next-pc source selection for the fetch-stage pc generator.
package pc_gen_pkg;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0020;
  localparam logic [31:0] BOOT_VECTOR  = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_FLUSH,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_PEND,
    SEL_SEQ
  } pc_sel_e;

  // A live branch beats a buffered one: the buffered target is older.
  function automatic pc_sel_e pc_select(input logic ce, input logic flush,
                                        input logic stall, input logic pend,
                                        input logic branch);
    if (!ce)         return SEL_RESET;
    else if (flush)  return SEL_FLUSH;
    else if (stall)  return SEL_HOLD;
    else if (branch) return SEL_BRANCH;
    else if (pend)   return SEL_PEND;
    else             return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a taken-branch target that arrived while fetch was stalled until the stall lifts.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              redirect_pend,
  output logic [ADDR_W-1:0] pend_target
);

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pend <= 1'b0;
      pend_target   <= '0;
    end else if (ce) begin
      if (flush) begin
        redirect_pend <= 1'b0;
      end else if (stall) begin
        if (branch_flag) begin
          redirect_pend <= 1'b1;
          pend_target   <= branch_target;
        end
      end else begin
        redirect_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall, branch redirect, buffered redirect and flush.
// Optional PC_ALIGN_CHK_EN adds a registered pc_misalign flag for AdEL reporting.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_pend
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic              pc_misalign
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] INC    = ADDR_W'(PC_INC);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_target;

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .stall         (stall),
    .flush         (flush),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .redirect_pend (redirect_pend),
    .pend_target   (pend_target)
  );

  always_comb begin
    sel    = pc_select(ce, flush, stall, redirect_pend, branch_flag);
    pc_nxt = pc;
    case (sel)
      SEL_RESET:  pc_nxt = RST_PC;
      SEL_FLUSH:  pc_nxt = new_pc;
      SEL_HOLD:   pc_nxt = pc;
      SEL_BRANCH: pc_nxt = branch_target;
      SEL_PEND:   pc_nxt = pend_target;
      SEL_SEQ:    pc_nxt = pc + INC;
      default:    pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce <= 1'b0;
      pc <= RST_PC;
    end else begin
      ce <= 1'b1;
      pc <= pc_nxt;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic redirect_load;
  assign redirect_load = (sel == SEL_FLUSH) || (sel == SEL_BRANCH) || (sel == SEL_PEND);

  // Only redirected loads can introduce or remove misalignment; the flag rides with pc.
  always_ff @(posedge clk) begin
    if (rst)                pc_misalign <= 1'b0;
    else if (redirect_load) pc_misalign <= |pc_nxt[1:0];
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then randomized traffic vs a rule-level model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pend;
`ifdef PC_ALIGN_CHK_EN
  logic        pc_misalign;
`endif

  pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (pc),
    .ce            (ce),
    .redirect_pend (redirect_pend)
`ifdef PC_ALIGN_CHK_EN
    ,
    .pc_misalign   (pc_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state, advanced once per issued cycle
  logic [31:0] m_pc = 32'h0;
  logic        m_ce = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt = 32'h0;
  logic        m_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; new_pc = np; branch_flag = b; branch_target = bt;
    if (r) begin
      m_ce = 0; m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0; m_mis = 0;
    end else if (!m_ce) begin
      m_ce = 1; m_pc = 32'h0;
    end else if (f) begin
      m_pc = np; m_pend = 0; m_mis = (np % 4) != 0;
    end else if (s) begin
      if (b) begin m_pend = 1; m_tgt = bt; end
    end else if (b) begin
      m_pc = bt; m_pend = 0; m_mis = (bt % 4) != 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0; m_mis = (m_tgt % 4) != 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.ce = m_ce; e.pend = m_pend; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic idle(); step(0, 0, 0, 32'h0, 0, 32'h0); endtask

  // Monitor: pc/ce/redirect_pend are presented every cycle
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("ce", {31'h0, ce}, {31'h0, e.ce});
      check("redirect_pend", {31'h0, redirect_pend}, {31'h0, e.pend});
`ifdef PC_ALIGN_CHK_EN
      check("pc_misalign", {31'h0, pc_misalign}, {31'h0, e.mis});
`endif
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
    return a;
  endfunction

  initial begin
    repeat (3) step(1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 32'h40, 1, 32'h80);  // controls ignored while ce=0
    repeat (4) idle();                 // 4, 8, 12, 0x10
    step(0, 1, 0, 32'h0, 0, 32'h0);
    step(0, 1, 0, 32'h0, 0, 32'h0);
    idle();                            // 0x14
    step(0, 1, 0, 32'h0, 1, 32'h200);
    step(0, 1, 0, 32'h0, 0, 32'h0);
    idle();                            // 0x200
    idle();                            // 0x204
    step(0, 1, 0, 32'h0, 1, 32'h200);
    step(0, 1, 1, 32'h180, 0, 32'h0);  // flush beats stall and pending
    idle();                            // 0x184
    step(0, 1, 0, 32'h0, 1, 32'h400);
    step(0, 1, 0, 32'h0, 1, 32'h500);  // newest pending wins
    step(0, 0, 0, 32'h0, 1, 32'h600);  // live branch beats pending
    idle();
    step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    idle();                            // wrap to 0
    step(0, 0, 0, 32'h0, 1, 32'h102);
    step(0, 0, 0, 32'h0, 1, 32'h300);
    step(0, 1, 0, 32'h0, 1, 32'h700);
    step(1, 1, 0, 32'h0, 0, 32'h0);    // reset discards pending
    idle();
    idle();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8,
           rand_addr(), $urandom_range(0, 3) == 0, rand_addr());
    end
    idle();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator at the head of the fetch stage of the 5-stage MIPS pipeline.
- Drives the instruction-memory address (pc) and chip enable (ce).
- Supports pipeline stall, branch/jump redirect and exception flush.
- Buffers a redirect that arrives while the fetch stage is stalled, so no taken branch is lost.

Parameters:
- ADDR_W, 32, width of pc and all target buses.
- RESET_PC, 32'h0000_0000, first fetch address after reset release; truncated to ADDR_W.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  fetch stall from the stall controller; holds pc
- flush  in  1  exception/eret flush; forces pc to new_pc
- new_pc  in  ADDR_W  exception vector or EPC target, valid with flush
- branch_flag  in  1  taken branch/jump from ID
- branch_target  in  ADDR_W  branch/jump target, valid with branch_flag
- pc  out  ADDR_W  current fetch address
- ce  out  1  instruction-memory enable
- redirect_pend  out  1  a buffered redirect is waiting for stall release
- pc_misalign  out  1  only when PC_ALIGN_CHK_EN is defined; see Optional Feature

Behaviour:
- All state is updated on posedge clk. Reset is synchronous: rst high at an edge forces ce=0, pc=RESET_PC, redirect_pend=0, pend_target=0.
- ce is registered from rst: ce is 0 during reset and goes to 1 at the first edge with rst=0.
- While ce=0, next pc=RESET_PC. As a result, the first cycle with ce=1 presents pc=RESET_PC, and RESET_PC+PC_INC follows on the next non-stalled edge.
- When ce=1, next pc is chosen by this priority (highest first):
  1. flush: pc<=new_pc; redirect_pend<=0. Applies even if stall=1.
  2. stall: pc holds. If branch_flag=1, pend_target<=branch_target and redirect_pend<=1. A new branch_flag while already pending overwrites the target (newest wins).
  3. redirect_pend=1, stall=0: pc<=pend_target; redirect_pend<=0. If branch_flag=1 in the same cycle, the pending target is ignored and branch_target is used.
  4. branch_flag=1: pc<=branch_target.
  5. Otherwise: pc<=pc+PC_INC, modulo 2^ADDR_W (wraps from all-ones-minus-3 to 0, no flag).
- The delay slot is handled by ID timing: branch_flag arrives while the delay-slot instruction is being fetched. pc_gen adds no extra slot logic.
- Latency: redirect to pc is one edge. A buffered redirect is applied one edge after stall falls.
- Reset mid-stall or mid-pending discards the pending redirect.
- flush, stall and branch_flag are ignored while ce=0.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro name: PC_ALIGN_CHK_EN.
- Defined: pc_misalign is a registered flag, set when the loaded pc[1:0]!=0 (from new_pc, branch_target or pend_target) and cleared on the next load of an aligned value. The bit is carried alongside pc for the AdEL exception; the pc value is still loaded unchanged. Reset value is 0.
- Undefined: the pc_misalign port and its logic are absent.

Decomposition:
- Shared defines: `ZeroWord, `Enable/`Disable, `InstAddrBus and the exception-vector constants all go in the existing defines.v.
- One natural sub-module, pc_redirect_buf: holds pend_target and redirect_pend, with set/clear/flush logic.

Test Plan:
- Reset and start: rst=1 for 3 cycles, then 0 → ce=0, pc=0 during reset; ce=1 with pc=0 at edge 1; then pc=4, 8, 12.
- Stall: stall=1 for 2 cycles at pc=0x10 → pc holds 0x10, then 0x14 after release.
- Branch while stalled: stall=1 with branch_flag=1 and target 0x200 → redirect_pend=1, pc held; on stall=0, pc=0x200 and pend cleared next edge; then 0x204.
- Flush priority: stall=1, redirect pending to 0x200, then flush=1 with new_pc=0x180 → pc=0x180, redirect_pend=0; following fetch is 0x184.
- Wrap: pc=0xFFFF_FFFC, no events → pc=0x0000_0000.
- Misaligned target (with PC_ALIGN_CHK_EN defined): branch_target=0x102 → pc=0x102, pc_misalign=1; then branch to 0x300 → pc_misalign=0.
